// File: rtl/ddr_pkg.sv
// ddr_pkg: constants and helpers shared by the DDR transmit path.
// The serializer FSM encoding, the idle output level and a clog2 helper
// live here. The ODDR wrapper reads its INIT value from DDR_IDLE_LEVEL.
package ddr_pkg;

    // Serializer FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Level driven on the pin while no word is in flight. It must match the
    // DDR primitive's INIT value so that the pin does not glitch out of reset.
    localparam logic DDR_IDLE_LEVEL = 1'b1;

    // Number of bits needed to hold the values 0..n-1. Returns 0 for n <= 1.
    function automatic int ddr_clog2(input int n);
        int v;
        int b;
        v = n - 1;
        b = 0;
        while (v > 0) begin
            b = b + 1;
            v = v >> 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer: turns W-bit words into a stream of bit pairs for the
// ODDR stage. d[0] is sent in the rising half-cycle and d[1] in the falling
// half-cycle. en marks every cycle whose pair carries word data.
//
// Build option: define DDR_TX_GAPLESS_EN so that in_ready is also raised
// during the last-pair cycle. Back-to-back words then stream with no idle
// cycle between them. Without the macro, each word is followed by at least
// one idle cycle.
//
// state    | meaning
// ST_IDLE  | d at idle level, en low, in_ready high (one edge after reset)
// ST_SHIFT | d carries pair r_cnt of the current word, en high
module ddr_tx_serializer
    import ddr_pkg::*;
#(
    parameter int   W          = 16,
    parameter logic IDLE_LEVEL = DDR_IDLE_LEVEL,
    parameter int   MSB_FIRST  = 1
) (
    input  logic         c,
    input  logic         r,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [1:0]   d,
    output logic         en,
    output logic         busy
);

    localparam int NPAIR   = W / 2;
    localparam int CW_RAW  = ddr_clog2(NPAIR);
    localparam int CW      = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST_CNT  = CW'(NPAIR - 1);
    localparam logic [1:0]    IDLE_PAIR = {IDLE_LEVEL, IDLE_LEVEL};

`ifdef DDR_TX_GAPLESS_EN
    localparam bit GAPLESS = 1'b1;
`else
    localparam bit GAPLESS = 1'b0;
`endif

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_shift;
    logic [1:0]    r_d;
    logic          r_en;
    logic          r_ready;

    logic [0:0]    w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [W-1:0]  w_shift_nx;
    logic [1:0]    w_d_nx;
    logic          w_en_nx;
    logic          w_ready_nx;
    logic          w_xfer;
    logic          w_last;
    logic          w_load;

    // Pair that goes out first from a word, as {d[1], d[0]}
    function automatic logic [1:0] head_pair(input logic [W-1:0] word);
        if (MSB_FIRST != 0) begin
            return {word[W-2], word[W-1]};
        end else begin
            return word[1:0];
        end
    endfunction

    // Word with its head pair removed, so the next pair becomes the head.
    // The vacated bits are zero-filled so no stale data lingers.
    function automatic logic [W-1:0] drop_pair(input logic [W-1:0] word);
        if (MSB_FIRST != 0) begin
            return {word[W-3:0], 2'b00};
        end else begin
            return {2'b00, word[W-1:2]};
        end
    endfunction

    assign w_xfer = in_valid && r_ready;
    assign w_last = (r_cnt == LAST_CNT);

    // Next-state decode. All outputs are computed one cycle ahead so that
    // d, en and in_ready leave this block straight from flops.
    always_comb begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_shift_nx = '0;
        w_d_nx     = IDLE_PAIR;
        w_en_nx    = 1'b0;
        w_load     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_state_nx = ST_SHIFT;
                    w_cnt_nx   = r_cnt + CW'(1);
                    w_d_nx     = head_pair(r_shift);
                    w_shift_nx = drop_pair(r_shift);
                    w_en_nx    = 1'b1;
                end else if (GAPLESS && w_xfer) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        // A new word puts its first pair out on the very next cycle; the rest
        // of the word waits in the shift register.
        if (w_load) begin
            w_state_nx = ST_SHIFT;
            w_cnt_nx   = '0;
            w_d_nx     = head_pair(in_data);
            w_shift_nx = drop_pair(in_data);
            w_en_nx    = 1'b1;
        end

        w_ready_nx = (w_state_nx == ST_IDLE) ||
                     (GAPLESS && (w_state_nx == ST_SHIFT) && (w_cnt_nx == LAST_CNT));
    end

    // State and output registers. Reset drops d to idle without a clock, which
    // aborts any word in flight.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_d     <= IDLE_PAIR;
            r_en    <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_d     <= w_d_nx;
            r_en    <= w_en_nx;
            r_ready <= w_ready_nx;
        end
    end

    assign d        = r_d;
    assign en       = r_en;
    assign in_ready = r_ready;
    // A transfer always moves the FSM into SHIFT on the same edge, so being
    // in SHIFT covers both "word on the pins" and "word just accepted".
    assign busy     = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// tb_ddr_tx_serializer: three serializer instances (W=16 MSB-first,
// W=16 LSB-first, W=4 MSB-first) share a clock and reset. A pair-index
// model predicts every output each cycle. Directed sequences pin the model
// with literal pair values, and a W=4 stream checks word reassembly.
module tb_ddr_tx_serializer;

    logic c = 1'b0;
    logic r = 1'b0;
    always #5 c = ~c;

`ifdef DDR_TX_GAPLESS_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        vld[3];
    logic [15:0] dat[3];
    logic [1:0]  dd[3];
    logic        en_o[3];
    logic        rdy[3];
    logic        bsy[3];

    ddr_tx_serializer #(.W(16), .IDLE_LEVEL(1'b1), .MSB_FIRST(1)) u_msb (
        .c(c), .r(r), .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .d(dd[0]), .en(en_o[0]), .busy(bsy[0]));

    ddr_tx_serializer #(.W(16), .IDLE_LEVEL(1'b1), .MSB_FIRST(0)) u_lsb (
        .c(c), .r(r), .in_data(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .d(dd[1]), .en(en_o[1]), .busy(bsy[1]));

    ddr_tx_serializer #(.W(4), .IDLE_LEVEL(1'b1), .MSB_FIRST(1)) u_w4 (
        .c(c), .r(r), .in_data(dat[2][3:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .d(dd[2]), .en(en_o[2]), .busy(bsy[2]));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int pw(input int i);
        return (i == 2) ? 4 : 16;
    endfunction

    function automatic int pm(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    // Pair k of word w as {d[1], d[0]}
    function automatic logic [1:0] exp_pair(input logic [15:0] w, input int k,
                                            input int wd, input int msb);
        if (msb != 0) return {w[wd-2-2*k], w[wd-1-2*k]};
        else          return {w[2*k+1], w[2*k]};
    endfunction

    // Model: m_k is the index of the pair on d (-1 = idle)
    int          m_k[3];
    logic [15:0] m_word[3];
    logic        m_rdy[3];
    logic        m_xf;

    always @(posedge c or posedge r) begin
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_k[i] = -1; m_rdy[i] = 1'b0; m_word[i] = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_xf = vld[i] && m_rdy[i];
                if (m_k[i] >= 0 && m_k[i] < pw(i)/2 - 1) m_k[i] = m_k[i] + 1;
                else if (m_xf) begin m_word[i] = dat[i]; m_k[i] = 0; end
                else m_k[i] = -1;
                m_rdy[i] = (m_k[i] < 0) || (GAP && m_k[i] == pw(i)/2 - 1);
            end
        end
    end

    // Per-cycle comparison of {d, en, in_ready, busy} against the model
    always @(negedge c) begin
        for (int i = 0; i < 3; i++) begin
            logic [4:0] e;
            if (m_k[i] < 0) e = {2'b11, 1'b0, m_rdy[i], 1'b0};
            else e = {exp_pair(m_word[i], m_k[i], pw(i), pm(i)), 1'b1, m_rdy[i], 1'b1};
            check($sformatf("cycle_dut%0d", i), {27'b0, dd[i], en_o[i], rdy[i], bsy[i]}, {27'b0, e});
        end
    end

    // W=4 scoreboard: rebuild words from pairs and match against sent words
    logic [3:0] sent[$];
    int  en_cnt = 0;
    int  rx_cnt = 0;
    int  ph = 0;
    logic [1:0] p0;
    always @(negedge c) begin
        if (!r && en_o[2]) begin
            en_cnt++;
            if (ph == 0) begin
                p0 = dd[2]; ph = 1;
            end else begin
                ph = 0;
                rx_cnt++;
                if (sent.size() == 0) begin
                    n_chk++;
                    $display("FAIL t6_unexpected_word: got %0h expected none", {p0[0], p0[1], dd[2][0], dd[2][1]});
                end else begin
                    check("t6_word", {28'b0, p0[0], p0[1], dd[2][0], dd[2][1]}, {28'b0, sent.pop_front()});
                end
            end
        end
    end

    task automatic tick;
        @(negedge c);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    logic [1:0] t1[8];
    logic [1:0] t5[8];
    logic [2:0] h3[20];
    int cnt;
    int start2;
    int guard;
    logic [3:0] w4;

    initial begin
        for (int i = 0; i < 3; i++) begin vld[i] = 1'b0; dat[i] = '0; end
        t1 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11};
        t5 = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00};

        // Reset state
        #1 r = 1'b1;
        tick; tick;
        check("rst_d", dd[0], 2'b11);
        check("rst_en_busy_rdy", {en_o[0], bsy[0], rdy[0]}, 3'b000);
        tick;
        r = 1'b0;
        check("rdy_before_edge", rdy[0], 1'b0);
        tick;
        check("rdy_after_edge", rdy[0], 1'b1);

        // 1: A5C3 MSB-first
        dat[0] = 16'hA5C3; vld[0] = 1'b1;
        @(posedge c);
        for (int k = 0; k < 8; k++) begin
            tick;
            if (k == 0) vld[0] = 1'b0;
            check($sformatf("t1_pair%0d", k), {en_o[0], dd[0]}, {1'b1, t1[k]});
        end
        tick;
        check("t1_idle", {en_o[0], dd[0]}, 3'b011);
        check("t1_rdy_back", rdy[0], 1'b1);

        // 2: 0001 LSB-first
        dat[1] = 16'h0001; vld[1] = 1'b1;
        @(posedge c);
        for (int k = 0; k < 8; k++) begin
            tick;
            if (k == 0) vld[1] = 1'b0;
            check($sformatf("t2_pair%0d", k), {en_o[1], dd[1]}, {1'b1, (k == 0) ? 2'b01 : 2'b00});
        end
        tick;
        check("t2_idle", {en_o[1], dd[1]}, 3'b011);

        // 3: FFFF then 0000 with valid held
        tick;
        dat[0] = 16'hFFFF; vld[0] = 1'b1;
        start2 = GAP ? 9 : 10;
        @(posedge c);
        for (int j = 1; j <= 19; j++) begin
            tick;
            if (j == 1) dat[0] = 16'h0000;
            h3[j] = {en_o[0], dd[0]};
            if (j == start2) vld[0] = 1'b0;
        end
        cnt = 0;
        for (int j = 1; j <= 19; j++) if (h3[j][2]) cnt++;
        check("t3_en_count", cnt, 16);
        check("t3_cycle9", h3[9], GAP ? 3'b100 : 3'b011);
        check("t3_w2_first", h3[start2], 3'b100);
        check("t3_w1_last", h3[8], 3'b111);
        check("t3_after", h3[start2 + 8], 3'b011);

        // 4: async reset at pair 3
        tick;
        dat[0] = 16'hA5C3; vld[0] = 1'b1;
        @(posedge c);
        for (int j = 1; j <= 4; j++) begin
            tick;
            if (j == 1) vld[0] = 1'b0;
        end
        check("t4_pair3", {en_o[0], dd[0]}, 3'b110);
        #1 r = 1'b1;
        #1;
        check("t4_async_idle", {en_o[0], dd[0]}, 3'b011);
        check("t4_async_busy_rdy", {bsy[0], rdy[0]}, 2'b00);
        tick; tick;
        r = 1'b0;
        check("t4_rdy_hold", rdy[0], 1'b0);
        tick;
        check("t4_rdy_after", rdy[0], 1'b1);
        dat[0] = 16'h8000; vld[0] = 1'b1;
        @(posedge c);
        for (int k = 0; k < 8; k++) begin
            tick;
            if (k == 0) vld[0] = 1'b0;
            check($sformatf("t4_pair%0d", k), {en_o[0], dd[0]}, {1'b1, (k == 0) ? 2'b01 : 2'b00});
        end
        tick;
        check("t4_idle", {en_o[0], dd[0]}, 3'b011);

        // 5: valid pulses and data churn during SHIFT
        dat[0] = 16'h1234; vld[0] = 1'b1;
        @(posedge c);
        for (int j = 1; j <= 12; j++) begin
            tick;
            dat[0] = 16'($urandom);
            vld[0] = (j == 3 || j == 5);
            if (j <= 8) check($sformatf("t5_pair%0d", j - 1), {en_o[0], dd[0]}, {1'b1, t5[j-1]});
            else check($sformatf("t5_idle%0d", j), {en_o[0], dd[0]}, 3'b011);
        end
        vld[0] = 1'b0;

        // 6: W=4 stream of 1000 words
        tick;
        for (int n = 0; n < 1000; n++) begin
            w4 = 4'($urandom_range(0, 15));
            dat[2] = {12'b0, w4};
            vld[2] = 1'b1;
            guard = 0;
            while (!rdy[2] && guard < 20) begin tick; guard++; end
            if (guard >= 20) begin
                n_chk++;
                $display("FAIL t6_ready_timeout: in_ready low for %0d cycles, expected high", guard);
                break;
            end
            @(posedge c);
            sent.push_back(w4);
            tick;
        end
        vld[2] = 1'b0;
        repeat (6) tick;
        check("t6_rx_count", rx_cnt, 1000);
        check("t6_en_cycles", en_cnt, 2000);
        check("t6_queue_drained", sent.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr_tx_serializer.md
Name: ddr_tx_serializer

Overview:
- Parallel-to-DDR serializer feeding the 2-bit ODDR output wrapper.
- Accepts W-bit words on a valid/ready handshake and emits 2 bits per clock on d[1:0].
- d[0] goes out in the first (rising, C0) half-cycle; d[1] goes out in the second half.
- Sits between the transmit datapath and the pin-level DDR primitive; also produces a frame-enable for the companion strobe/enable pin.

Parameters:
- W, 16: word width in bits. Must be even and >= 4.
- IDLE_LEVEL, 1: bit value driven on both d bits when not transmitting. Matches the DDR primitive's INIT.
- MSB_FIRST, 1: 1 = bit W-1 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
- c, input, 1: clock; same clock that drives the DDR primitive.
- r, input, 1: reset, asynchronous, active-high.
- in_data, input, W: word to transmit.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block will accept in_data at the next rising edge of c.
- d, output, 2: DDR bit pair for the ODDR stage; d[0] first half-cycle, d[1] second.
- en, output, 1: high on every cycle d carries word data.
- busy, output, 1: word in flight (en, or a word accepted but not yet started).

Behaviour:
- Reset (r high, asynchronous): d={IDLE_LEVEL,IDLE_LEVEL}, en=0, busy=0, in_ready=0, shift register and pair counter cleared.
- After reset: in_ready rises at the first edge after r falls.
- Reset mid-word aborts the word. The remaining bits are discarded and d returns to idle immediately, without waiting for a clock.
- Handshake:
  - Transfer occurs at a rising edge with in_valid && in_ready.
  - in_data is sampled only at transfer.
  - in_valid may drop without a transfer; there is no requirement that valid be held.
- States:
  - IDLE: in_ready=1, en=0, d=idle. On transfer, go to SHIFT with count=0.
  - SHIFT: en=1 and d carries pair number count. count increments each cycle, range 0..W/2-1.
  - At count==W/2-1 the next state is IDLE. In gapless mode, if a transfer occurs on that cycle, the next state is SHIFT with count=0.
- Latency: a word transferred at edge N puts its first pair on d during cycle N+1 (registered outputs). en stays high for exactly W/2 consecutive cycles.
- Bit order with MSB_FIRST=1: pair k is d[0]=word[W-1-2k], d[1]=word[W-2-2k]. With MSB_FIRST=0: d[0]=word[2k], d[1]=word[2k+1].
- in_ready is registered and is low throughout SHIFT, except in the last-pair cycle when the gapless feature is enabled.
- When no word follows, d returns to idle on the cycle after the last pair, with en=0 on the same cycle.
- Counter width is clog2(W/2), minimum 1. The counter never wraps mid-word.
- busy = en or a transfer on the current edge. It is combinational from state only; no dependency on in_valid.

Optional Feature:
- Macro: DDR_TX_GAPLESS_EN.
- Defined: in_ready is also high during the last-pair cycle of SHIFT. A transfer then makes the next word's first pair follow immediately, so back-to-back words stream continuously with en held high.
- Undefined: in_ready is high only in IDLE. Consecutive words are separated by at least one idle cycle (d=idle, en=0).

Decomposition:
- Shared package ddr_pkg holds:
  - the state encoding constants (ST_IDLE, ST_SHIFT);
  - the clog2 function;
  - the default idle level constant shared with the ODDR wrapper's INIT.
- No sub-module: shift register, counter and FSM stay in one module. The ODDR primitive is instantiated by the parent, not inside this block.

Test Plan:
1. W=16, MSB_FIRST=1: transfer 16'hA5C3 at edge N → cycles N+1..N+8 give (d[0],d[1]) = (1,0),(1,0),(0,1),(0,1),(1,1),(0,0),(0,0),(1,1); en=1 on exactly those 8 cycles; cycle N+9 gives d=2'b11, en=0.
2. MSB_FIRST=0, word 16'h0001 → first pair d[0]=1, d[1]=0; all later pairs are 0; 8 pairs total.
3. in_valid held high with words 16'hFFFF then 16'h0000, macro undefined → exactly 1 idle cycle between words; the second word starts at cycle N+10. With the macro defined → no gap, and the second word's first pair is on cycle N+9.
4. Assert r asynchronously at pair 3 of 16'hA5C3 → d=2'b11 and en=0 before the next edge; after release, in_ready=1 one edge later, and a new word 16'h8000 transmits correctly with first pair (1,0).
5. in_valid pulses while in SHIFT, macro undefined → no transfer; the word is ignored unless valid is still high in IDLE. Verify in_data changes during SHIFT do not corrupt the pairs being transmitted.
6. W=4, random words back-to-back, 1000 words → a scoreboard built from reassembled pairs matches the sent words; en duty equals W/2 cycles per word.
